// File: rtl/param_mem.sv
// param_mem: single-port word memory behind a valid/ready request channel
// and a valid/ready response channel. One transaction in flight at a time.
// Each access completes READ_LATENCY cycles after the request is accepted.
module param_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 1024,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_data_o,
  output logic                    resp_err_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_SIZE);
  // First byte address past the end of the memory.
  localparam longint unsigned LIMIT = longint'(MEM_SIZE) * longint'(BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]        wstrb_q, wstrb_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;

  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             out_of_range;
  logic             access_err;
  logic             do_access;
  logic             do_write;
  logic             rd_ok;

  // Decode of the latched address; all checks use the latched copy.
  assign idx          = addr_q[OFF_W +: IDX_W];
  assign out_of_range = 64'(addr_q) >= LIMIT;
  assign access_err   = misaligned | out_of_range;

  generate
    if (OFF_W == 0) begin : g_no_align
      assign misaligned = 1'b0;
    end else begin : g_align
      assign misaligned = |addr_q[OFF_W-1:0];
    end
  endgenerate

  // The access happens on the edge where the counter steps from 1 to 0.
  assign do_access = (state_q == WAIT) && (cnt_q == 4'd1) && !rst;
  assign do_write  = do_access && we_q && !access_err;
  assign rd_ok     = !we_q && !access_err;

  // One byte-wide RAM per lane so byte strobes map onto independent write enables.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] lane_q [MEM_SIZE] = '{default: 8'h00};
      logic [7:0] rd_lane_q;

      // Lane write, gated by its strobe bit.
      always_ff @(posedge clk) begin
        if (do_write && wstrb_q[gi]) begin
          lane_q[idx] <= wdata_q[8*gi +: 8];
        end
      end

      // Registered lane read; zero for writes and errored accesses.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_lane_q <= 8'h00;
        end else if (do_access) begin
          rd_lane_q <= rd_ok ? lane_q[idx] : 8'h00;
        end
      end

      assign resp_data_o[8*gi +: 8] = rd_lane_q;
    end
  endgenerate

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          we_d        = req_we_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          wstrb_d     = req_wstrb_i;
          cnt_d       = 4'(READ_LATENCY);
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          resp_valid_d = 1'b1;
          resp_err_d   = access_err;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_param_mem.sv
// Bench for param_mem: a 32-bit, latency-3 instance checked against a
// byte-addressed reference model, plus a 64-bit, latency-1 instance.
module tb_param_mem;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // 32-bit instance signals
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;

  // 64-bit instance signals
  logic        req_valid64 = 1'b0;
  logic        req_ready64;
  logic        req_we64 = 1'b0;
  logic [31:0] req_addr64 = '0;
  logic [63:0] req_wdata64 = '0;
  logic [7:0]  req_wstrb64 = '0;
  logic        resp_valid64;
  logic        resp_ready64 = 1'b0;
  logic [63:0] resp_data64;
  logic        resp_err64;

  param_mem #(.DATA_WIDTH(32), .MEM_SIZE(1024), .READ_LATENCY(LAT), .ADDR_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_err_o(resp_err)
  );

  param_mem #(.DATA_WIDTH(64), .MEM_SIZE(1024), .READ_LATENCY(1), .ADDR_WIDTH(32)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid64), .req_ready_o(req_ready64), .req_we_i(req_we64),
    .req_addr_i(req_addr64), .req_wdata_i(req_wdata64), .req_wstrb_i(req_wstrb64),
    .resp_valid_o(resp_valid64), .resp_ready_i(resp_ready64),
    .resp_data_o(resp_data64), .resp_err_o(resp_err64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a plain byte array of 1024 32-bit words.
  logic [7:0] mdl [4096];
  initial for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  bit   seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply one transaction to the model; returns the response it must produce.
  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                output logic err, output logic [31:0] data);
    err  = (addr % 4 != 0) || (addr >= 32'd4096);
    data = 32'h0;
    if (!err) begin
      for (int b = 0; b < 4; b++) begin
        if (we && wstrb[b]) mdl[addr + b] = wdata[8*b +: 8];
        if (!we) data[8*b +: 8] = mdl[addr + b];
      end
    end
  endfunction

  // Compare process: every cycle a response is shown, it must match the model.
  initial forever begin
    @(negedge clk);
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        if (!seen) begin
          chk("resp_latency", 64'(cyc), 64'(exp_q[0].cyc));
          seen = 1;
        end
        chk("resp_data", 64'(resp_data), 64'(exp_q[0].data));
        chk("resp_err", 64'(resp_err), 64'(exp_q[0].err));
        chk("ready_low_in_resp", 64'(req_ready), 64'd0);
      end
    end
  end

  // Drive one request, optionally stall the response, return what was seen.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int hold,
                     output logic [31:0] rdata, output logic rerr);
    int t;
    exp_t e;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model(we, addr, wdata, wstrb, e.err, e.data);
    e.cyc = cyc + LAT;
    seen  = 0;
    exp_q.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!resp_valid && t < 40);
    chk("resp_timeout", 64'(resp_valid), 64'd1);
    rdata = resp_data;
    rerr  = resp_err;
    if (hold > 0) begin
      // A competing write to word 0 while busy must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0;
      req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_ready_low", 64'(req_ready), 64'd0);
        chk("hold_valid_high", 64'(resp_valid), 64'd1);
      end
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("ready_after_hs", 64'(req_ready), 64'd1);
    chk("valid_after_hs", 64'(resp_valid), 64'd0);
  endtask

  task automatic txn64(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] req_data);
    int t;
    int acc;
    @(negedge clk);
    req_valid64 = 1'b1; req_we64 = we; req_addr64 = addr;
    req_wdata64 = wdata; req_wstrb64 = 8'hFF;
    chk("ready64", 64'(req_ready64), 64'd1);
    @(posedge clk);
    #1;
    req_valid64 = 1'b0;
    acc = cyc;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!resp_valid64 && t < 20);
    chk("resp64_latency", 64'(cyc - acc), 64'd1);
    chk("resp64_data", resp_data64, req_data);
    chk("resp64_err", 64'(resp_err64), 64'd0);
    resp_ready64 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready64 = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        er;
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        er;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_data", 64'(resp_data), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Memory starts at zero.
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, d, er);
    chk("init_zero", 64'(d), 64'h0);

    // Full write then read back.
    txn(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, d, er);
    chk("wr_data_zero", 64'(d), 64'h0);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, d, er);
    chk("rd_deadbeef", 64'(d), 64'hDEADBEEF);
    chk("rd_deadbeef_err", 64'(er), 64'h0);

    // Single-byte strobe.
    txn(1'b1, 32'h40, 32'h000000AA, 4'h1, 0, d, er);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, d, er);
    chk("rd_deadbeaa", 64'(d), 64'hDEADBEAA);

    // Out-of-range write aliases word 0 by index and must not touch it.
    txn(1'b1, 32'h0, 32'h11223344, 4'hF, 0, d, er);
    txn(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, d, er);
    chk("oor_wr_err", 64'(er), 64'h1);
    txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, d, er);
    chk("oor_rd_err", 64'(er), 64'h1);
    chk("oor_rd_data", 64'(d), 64'h0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, d, er);
    chk("word0_kept", 64'(d), 64'h11223344);

    // Misaligned accesses.
    txn(1'b0, 32'h42, 32'h0, 4'h0, 0, d, er);
    chk("mis_rd_err", 64'(er), 64'h1);
    chk("mis_rd_data", 64'(d), 64'h0);
    txn(1'b1, 32'h42, 32'h99999999, 4'hF, 0, d, er);
    chk("mis_wr_err", 64'(er), 64'h1);

    // Zero strobe write completes without change.
    txn(1'b1, 32'h40, 32'h12345678, 4'h0, 0, d, er);
    chk("wstrb0_err", 64'(er), 64'h0);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, d, er);
    chk("wstrb0_kept", 64'(d), 64'hDEADBEAA);

    // Sparse strobe: bytes 1 and 3.
    txn(1'b1, 32'h40, 32'h55667788, 4'hA, 0, d, er);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, d, er);
    chk("rd_sparse", 64'(d), 64'h55AD77AA);

    // Last word of the memory.
    txn(1'b1, 32'hFFC, 32'hA5A55A5A, 4'hF, 0, d, er);
    txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0, d, er);
    chk("rd_last_word", 64'(d), 64'hA5A55A5A);

    // Response stalled 5 cycles with a competing request.
    txn(1'b0, 32'h40, 32'h0, 4'h0, 5, d, er);
    chk("rd_held", 64'(d), 64'h55AD77AA);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, d, er);
    chk("ignored_req", 64'(d), 64'h11223344);

    // Reset during WAIT of a write drops it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0;
    req_wdata = 32'hBAD0BAD0; req_wstrb = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_valid", 64'(resp_valid), 64'd0);
    chk("abort_data", 64'(resp_data), 64'd0);
    chk("abort_err", 64'(resp_err), 64'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, d, er);
    chk("abort_word_kept", 64'(d), 64'h11223344);

    // 64-bit, one-cycle-latency instance.
    txn64(1'b1, 32'h8, 64'h0123456789ABCDEF, 64'h0);
    txn64(1'b0, 32'h8, 64'h0, 64'h0123456789ABCDEF);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
